bit_serial_alu_seq: RTL and testbench
=====================================

// Module: bit_serial_alu_seq
// PURPOSE
//  Bit-serial N-bit ALU sequencer built around a 1-bit ALU slice with carry.
//  Accepts two W-bit operands and an op code, then streams one bit pair per
//  clock into the slice, LSB first. A carry flip-flop chains the bits.
//  Collects result bits into a shift register and reports result, carry
//  and zero flags with a done pulse. Serves as the multi-bit front end for
//  the 1-bit ALU datapath.
// PARAMETERS
//  W  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk        in   1     system clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     request; sampled only in IDLE
//  op         in   2     00 AND, 01 OR, 10 ADD, 11 SUB (a-b); sampled with start
//  a_in       in   W     operand A; sampled with start
//  b_in       in   W     operand B; sampled with start
//  busy       out  1     high whenever state != IDLE
//  done       out  1     one-cycle pulse: result/flags valid
//  result     out  W     final result; held until the next accepted start
//  carry_out  out  1     ADD: final carry; SUB: 1 = no borrow; AND/OR: 0
//  zero       out  1     1 when result == 0; held with result
// BEHAVIOUR
//  Reset: one clock, asynchronous, active-low. rst_n low forces state=IDLE;
//   busy, done, carry_out, result and zero all 0; counter and shift regs 0.
//  FSM IDLE -> RUN on start; RUN -> DONE after W bit cycles; DONE -> IDLE
//   unconditionally after one cycle.
//  Accept edge (IDLE, start=1): load a_sh=a_in, b_sh=b_in, op_q=op,
//   cnt=0, carry=(op==SUB).
//  Each RUN edge: slice computes on a_sh[0], b_sh[0], carry, op_q.
//   SUB uses ~b bit. Shift the result bit into r_sh from the MSB side.
//   Shift a_sh and b_sh right. Update carry with slice cout for ADD/SUB;
//   carry is held for AND/OR. Increment cnt.
//  Final RUN edge (cnt==W-1): result<=assembled word; carry_out<=cout
//   (0 for AND/OR); zero<=(word==0); state<=DONE; done<=1.
//  Latency: done is high in the cycle following the W-th clock edge after
//   the accept edge. Throughput: one op per W+2 cycles.
//  start is ignored while busy (RUN or DONE). Operand changes during busy
//   have no effect.
//  Arithmetic is modulo 2^W. carry_out is the only overflow indication.
//  result, carry_out and zero change only on the final RUN edge or reset.
//  Reset asserted mid-operation aborts it immediately. No done is produced.
//   After release the block is in IDLE and accepts a new start.
//  cnt width is $clog2(W). cnt never exceeds W-1.
// STRUCTURE
//  alu_pkg: op code localparams OP_AND, OP_OR, OP_ADD, OP_SUB; state
//   encoding ST_IDLE, ST_RUN, ST_DONE.
//  Sub-module alu_bit_slice: combinational 1-bit ALU with inputs a, b, cin
//   and op; outputs r and cout. Instantiated once. The rest (FSM, counter,
//   shift registers, flags) lives in this module.
// TESTING (W=8)
//  ADD 8'h0F+8'h01 -> done exactly 8 edges after accept; result 8'h10,
//   carry_out 0, zero 0.
//  ADD 8'hFF+8'h01 -> result 8'h00, carry_out 1, zero 1.
//  SUB 8'h05-8'h07 -> result 8'hFE, carry_out 0. SUB 8'h07-8'h05 -> 8'h02,
//   carry_out 1.
//  AND 8'hF0&8'h3C -> 8'h30. OR 8'hF0|8'h0C -> 8'hFC. Both give carry_out 0.
//  start with ADD 1+1, then start pulsed with SUB mid-RUN, then in DONE ->
//   both ignored; result 8'h02, single done pulse, busy low next cycle.
//  rst_n low at bit 4 of ADD 8'hAA+8'h55 -> outputs 0 at once, no done.
//   After release ADD 8'h01+8'h01 -> 8'h02.

Source files
------------

// File: rtl/bit_serial_alu_seq_pkg.sv
// Shared op codes and sequencer states for the bit-serial ALU.
package bit_serial_alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bit_serial_alu_seq_slice.sv
// Combinational 1-bit ALU slice: AND/OR, or full add with optional b inversion for SUB.
module alu_bit_slice
  import bit_serial_alu_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout
);

  logic bx;

  always_comb begin
    bx   = (op_e'(op) == OP_SUB) ? ~b : b;
    r    = 1'b0;
    cout = 1'b0;
    case (op_e'(op))
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
      end
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial W-bit ALU sequencer: streams operands LSB first through one slice,
// chaining the carry in a flip-flop and assembling the result MSB-side.
module bit_serial_alu_seq
  import bit_serial_alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         zero
);

  localparam int CW = $clog2(W);

  state_e         state;
  op_e            op_q;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   r_sh;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           bit_r;
  logic           bit_cout;
  logic [W-1:0]   word;

  alu_bit_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_q),
    .r    (bit_r),
    .cout (bit_cout)
  );

  // Word as it stands once the current slice bit is shifted in.
  assign word = {bit_r, r_sh[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_AND;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            op_q  <= op_e'(op);
            cnt   <= '0;
            carry <= (op_e'(op) == OP_SUB);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sh <= word;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          if (op_is_arith(op_q)) carry <= bit_cout;
          if (cnt == CW'(W - 1)) begin
            cnt       <= '0;
            result    <= word;
            carry_out <= op_is_arith(op_q) ? bit_cout : 1'b0;
            zero      <= (word == '0);
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Randomized and directed checks of bit_serial_alu_seq against an arithmetic reference model.
module tb_bit_serial_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;

  int n_cmp;
  int n_err;

  bit_serial_alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on whole words.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c);
    longint unsigned sum;
    case (o)
      2'b00: begin r = a & b; c = 1'b0; end
      2'b01: begin r = a | b; c = 1'b0; end
      2'b10: begin
        sum = longint'(a) + longint'(b);
        r   = W'(sum);
        c   = sum[W];
      end
      default: begin
        r = W'(a - b);
        c = (a >= b);
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         ec;
    int           n;
    bit           got;
    model(o, a, b, er, ec);
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else begin
        chk("no_early_done_result_held", busy, 1);
        a_in = W'($urandom); b_in = W'($urandom); op = 2'($urandom);
      end
    end
    chk("latency", n, W);
    chk("result", result, er);
    chk("carry_out", carry_out, ec);
    chk("zero", zero, (er == '0));
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
    a_in = W'($urandom); b_in = W'($urandom);
    @(posedge clk); #1;
    chk("result_held", result, er);
  endtask

  initial begin
    int   dones;
    logic [1:0] ro;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(2'b10, 8'h0F, 8'h01);
    run_op(2'b10, 8'hFF, 8'h01);
    run_op(2'b11, 8'h05, 8'h07);
    run_op(2'b11, 8'h07, 8'h05);
    run_op(2'b00, 8'hF0, 8'h3C);
    run_op(2'b01, 8'hF0, 8'h0C);
    run_op(2'b11, 8'h33, 8'h33);
    run_op(2'b00, 8'hFF, 8'hFF);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, W'($urandom), W'($urandom));
    end

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    op = 2'b10; a_in = 8'h01; b_in = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start = 1'b0;
      if (k == 3) begin op = 2'b11; a_in = 8'h09; b_in = 8'h03; start = 1'b1; end
      if (done) begin op = 2'b11; a_in = 8'h40; b_in = 8'h01; start = 1'b1; end
    end
    start = 1'b0;
    chk("ignored_start_dones", dones, 1);
    chk("ignored_start_result", result, 8'h02);
    chk("ignored_start_busy", busy, 0);

    // reset mid-operation
    @(negedge clk);
    op = 2'b10; a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_carry", carry_out, 0);
    chk("abort_zero", zero, 0);
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (done) dones++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done) dones++; end
    chk("abort_no_done", dones, 0);
    run_op(2'b10, 8'h01, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
